// File: rtl/lane_demux_pkg.sv
// Shared types and constants for the lane_demux_n lane-to-channel demultiplexer.
// Lane-error detection is compiled in with macro LANE_DEMUX_ERR_EN.
package lane_demux_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

  localparam state_e RST_STATE = S_IDLE;
  localparam logic   RST_VALID = 1'b0;
  localparam logic   RST_DONE  = 1'b0;
  localparam logic   RST_ERR   = 1'b0;

  // clog2(r), floored at 1 so a single-phase build still has a phase bit
  function automatic int phase_w(input int r);
    int w;
    w = 1;
    while ((1 << w) < r) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/lane_demux_if.sv
// Bundle of the lane_demux_n data/valid/flush inputs and frame outputs.
// master drives lanes and flush; slave is the demux side.
interface lane_demux_if #(
  parameter int DATA_W   = 8,
  parameter int LANES_IN = 2,
  parameter int CH_OUT   = 4
) ();
  logic [LANES_IN*DATA_W-1:0] data_in;
  logic [LANES_IN-1:0]        valid_in;
  logic                       flush;
  logic [CH_OUT*DATA_W-1:0]   data_out;
  logic [CH_OUT-1:0]          valid_out;
  logic                       frame_done;
  logic                       err_lane;

  modport master (
    output data_in, valid_in, flush,
    input  data_out, valid_out, frame_done, err_lane
  );

  modport slave (
    input  data_in, valid_in, flush,
    output data_out, valid_out, frame_done, err_lane
  );
endinterface

// File: rtl/lane_demux_slot.sv
// One assembly slot: DATA_W register with load enable and async active-low clear.
module lane_demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk_f,
  input  logic              reset_L,
  input  logic              load_en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] word_q;

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L)     word_q <= '0;
    else if (load_en) word_q <= d;
  end

  assign q = word_q;
endmodule

// File: rtl/lane_demux_n.sv
// Gathers R = CH_OUT/LANES_IN full-lane beats into one CH_OUT-word frame.
// Optional sticky lane-misalignment flag under macro LANE_DEMUX_ERR_EN.
module lane_demux_n
  import lane_demux_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LANES_IN = 2,
  parameter int CH_OUT   = 4
) (
  input  logic                       clk_f,
  input  logic                       reset_L,
  input  logic [LANES_IN*DATA_W-1:0] data_in,
  input  logic [LANES_IN-1:0]        valid_in,
  input  logic                       flush,
  output logic [CH_OUT*DATA_W-1:0]   data_out,
  output logic [CH_OUT-1:0]          valid_out,
  output logic                       frame_done,
  output logic                       err_lane
);
  localparam int R  = CH_OUT / LANES_IN;
  localparam int PW = phase_w(R);
  localparam logic [PW-1:0] LAST = PW'(R - 1);

  logic                           beat, emit;
  state_e                         state_q, state_d;
  logic [PW-1:0]                  phase_q, phase_d;
  logic [CH_OUT-1:0]              slot_ld;
  logic [CH_OUT-1:0][DATA_W-1:0]  slot_q, frame_d, dout_q, dout_d;
  logic [CH_OUT-1:0]              vout_q, vout_d;
  logic                           done_q, done_d;

  assign beat = (&valid_in) & ~flush;
  assign emit = beat & (phase_q == LAST);

  // Slots of the current phase bypass straight into the emitted frame,
  // so the final beat does not need a cycle in the slot registers.
  for (genvar s = 0; s < CH_OUT; s++) begin : g_slot
    localparam int            LN = s % LANES_IN;
    localparam logic [PW-1:0] PH = PW'(s / LANES_IN);

    assign slot_ld[s] = beat & (phase_q == PH);
    assign frame_d[s] = (phase_q == PH) ? data_in[LN*DATA_W +: DATA_W] : slot_q[s];

    lane_demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk_f   (clk_f),
      .reset_L (reset_L),
      .load_en (slot_ld[s]),
      .d       (data_in[LN*DATA_W +: DATA_W]),
      .q       (slot_q[s])
    );
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dout_d  = dout_q;
    vout_d  = '0;
    done_d  = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      phase_d = '0;
    end else if (emit) begin
      state_d = S_IDLE;
      phase_d = '0;
      dout_d  = frame_d;
      vout_d  = '1;
      done_d  = 1'b1;
    end else if (beat) begin
      state_d = S_FILL;
      phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= RST_STATE;
      phase_q <= '0;
      dout_q  <= '0;
      vout_q  <= {CH_OUT{RST_VALID}};
      done_q  <= RST_DONE;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      done_q  <= done_d;
    end
  end

  assign data_out   = dout_q;
  assign valid_out  = vout_q;
  assign frame_done = done_q;

`ifdef LANE_DEMUX_ERR_EN
  logic partial, err_q, err_d;

  assign partial = (|valid_in) & ~(&valid_in);

  always_comb begin
    err_d = err_q;
    if (flush)        err_d = 1'b0;
    else if (partial) err_d = 1'b1;
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) err_q <= RST_ERR;
    else          err_q <= err_d;
  end

  assign err_lane = err_q;
`else
  assign err_lane = 1'b0;
`endif

endmodule

// File: doc/lane_demux_n.md
LANE_DEMUX_N -- requirements
Module: lane_demux_n

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of one data word.
REQ-002 SHALL have parameter LANES_IN, default 2, number of input lanes.
REQ-003 SHALL have parameter CH_OUT, default 4, number of output channels; CH_OUT is an integer multiple of LANES_IN; R = CH_OUT/LANES_IN.
REQ-004 SHALL have port clk_f  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_L  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port data_in  input  LANES_IN*DATA_W  lane i word at bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port valid_in  input  LANES_IN  per-lane valid.
REQ-008 SHALL have port flush  input  1  synchronous realign; discards any partial frame.
REQ-009 SHALL have port data_out  output  CH_OUT*DATA_W  channel c word at bits [c*DATA_W +: DATA_W].
REQ-010 SHALL have port valid_out  output  CH_OUT  per-channel valid.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when a full frame is emitted.
REQ-012 SHALL have port err_lane  output  1  sticky lane-misalignment flag (see Configuration).

Function
REQ-013 SHALL treat a cycle as a beat only when all valid_in bits are 1 and flush is 0.
REQ-014 SHALL keep a phase counter p, range 0..R-1, advancing by 1 per beat and wrapping from R-1 to 0.
REQ-015 SHALL store lane i's word of a beat at phase p into assembly slot p*LANES_IN+i.
REQ-016 SHALL run FSM S_IDLE (p=0, no stored words) -> S_FILL on a beat when R>1; S_FILL stays while p<R-1; the beat at p=R-1 emits and returns to S_IDLE.
REQ-017 SHALL, on the emitting beat at cycle t, drive data_out with all CH_OUT assembled words, valid_out all-ones and frame_done=1 during cycle t+1 only.
REQ-018 SHALL drive valid_out=0 and frame_done=0 in every non-emit cycle; data_out holds the last emitted frame.
REQ-019 SHALL sustain back-to-back frames: one frame every R cycles with continuous beats, with no bubble.
REQ-020 SHALL, with R=1, emit every beat (the FSM stays in S_IDLE).
REQ-021 SHALL treat valid_in all-zero as idle: no store, phase held, partial frame retained indefinitely.
REQ-022 SHALL treat partial valid_in (some bits set, not all) as a non-beat: no store, phase held.
REQ-023 SHALL, on flush=1, set p=0, enter S_IDLE, and discard the partial frame; any coincident valid data is dropped.
REQ-024 SHALL leave data_out unchanged by flush.

Reset
REQ-025 SHALL, while reset_L=0, immediately force data_out=0, valid_out=0, frame_done=0, err_lane=0, p=0 and S_IDLE, independent of clk_f.
REQ-026 SHALL discard any partial frame on reset; the first beat after release is phase 0.

Configuration
REQ-027 SHALL gate lane-error detection by macro LANE_DEMUX_ERR_EN.
REQ-028 SHALL, with LANE_DEMUX_ERR_EN defined, set err_lane on the edge after any partial-valid cycle; err_lane then holds 1 until reset_L=0 or flush=1.
REQ-029 SHALL, without LANE_DEMUX_ERR_EN, tie err_lane to 0 and include no error logic.

Structure
REQ-030 SHALL place FSM state encoding, the phase-width function clog2(R) (minimum 1) and reset constants in package lane_demux_pkg.
REQ-031 SHALL use one sub-module, lane_demux_slot: a DATA_W load-enabled register with async active-low clear, instantiated CH_OUT times for assembly.

Verification
REQ-032 SHALL test beats {8'hA0,8'hA1} then {8'hB0,8'hB1} -> next cycle data_out ch0..3 = A0,A1,B0,B1; valid_out=4'hF and frame_done=1 for exactly one cycle.
REQ-033 SHALL test beat, 2 idle cycles, beat -> no emit during the gap; the emit matches REQ-032; data_out holds its prior value meanwhile.
REQ-034 SHALL test valid_in=2'b01 mid-frame -> phase and slots unchanged; err_lane=1 sticky with LANE_DEMUX_ERR_EN, 0 without; then flush -> err_lane=0.
REQ-035 SHALL test one beat, flush, then beats {C0,C1},{D0,D1} -> emit C0,C1,D0,D1; the pre-flush word is absent.
REQ-036 SHALL test reset_L=0 mid-clock after one beat -> all outputs 0 before the next edge; after release, two beats form a fresh frame.
REQ-037 SHALL test 6 continuous beats -> frame_done pulses on cycles t+2, t+4 and t+6, with three correct frames.
